regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/reg_scoreboard.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and sizes for the register-file writeback arbiter
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;

    typedef logic [2:0] reg_idx_t;

    typedef struct packed {
        logic              valid;
        reg_idx_t          dr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Which writeback requester wins when both are valid
    typedef enum logic {
        PRIO_WB0 = 1'b0,
        PRIO_WB1 = 1'b1
    } prio_e;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard with issue gating and busy lookup
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    input  reg_idx_t        issue_dr_i,
    output logic            issue_ready_o,
    input  logic            clr_valid_i,
    input  reg_idx_t        clr_dr_i,
    input  reg_idx_t        sr1_i,
    input  reg_idx_t        sr2_i,
    output logic            sr1_busy_o,
    output logic            sr2_busy_o,
    output logic [NREG-1:0] pending_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // A register already awaiting a write cannot be claimed again; nothing is accepted in reset
    assign issue_ready_o = ~pending_q[issue_dr_i] & ~rst_i;

    // Busy reads the flop directly, so an issue this cycle is only visible next cycle
    assign sr1_busy_o = pending_q[sr1_i];
    assign sr2_busy_o = pending_q[sr2_i];
    assign pending_o  = pending_q;

    // Clear on committed write first, then set on issue so a same-bit collision stays set
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i) begin
            pending_d[clr_dr_i] = 1'b0;
        end
        if (issue_valid_i && issue_ready_o) begin
            pending_d[issue_dr_i] = 1'b1;
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for two writeback ports into the register file
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wb0_Valid,
    input  reg_idx_t          Wb0_DR,
    input  logic [DATA_W-1:0] Wb0_Data,
    output logic              Wb0_Ready,
    input  logic              Wb1_Valid,
    input  reg_idx_t          Wb1_DR,
    input  logic [DATA_W-1:0] Wb1_Data,
    output logic              Wb1_Ready,
    input  logic              Issue_Valid,
    input  reg_idx_t          Issue_DR,
    output logic              Issue_Ready,
    input  reg_idx_t          SR1,
    input  reg_idx_t          SR2,
    output logic              SR1_Busy,
    output logic              SR2_Busy,
    output logic              RF_Load,
    output reg_idx_t          RF_DR,
    output logic [DATA_W-1:0] RF_Data,
    output logic [NREG-1:0]   Pending
);

    wb_req_t req0;
    wb_req_t req1;
    wb_req_t wr_q;
    wb_req_t wr_d;
    prio_e   prio_q;
    prio_e   prio_d;
    logic    wb0_grant;
    logic    wb1_grant;

    assign req0 = '{valid: Wb0_Valid, dr: Wb0_DR, data: Wb0_Data};
    assign req1 = '{valid: Wb1_Valid, dr: Wb1_DR, data: Wb1_Data};

    // Grant decision, priority flip and next write-register contents
    always_comb begin
        wb0_grant = 1'b0;
        wb1_grant = 1'b0;
        prio_d    = prio_q;
        wr_d      = wr_q;
        wr_d.valid = 1'b0;
        if (!Reset) begin
            if (req0.valid && (!req1.valid || prio_q == PRIO_WB0)) begin
                wb0_grant = 1'b1;
            end else if (req1.valid) begin
                wb1_grant = 1'b1;
            end
        end
        if (wb0_grant) begin
            prio_d = PRIO_WB1;
            wr_d   = req0;
        end else if (wb1_grant) begin
            prio_d = PRIO_WB0;
            wr_d   = req1;
        end
    end

    // Priority pointer and registered register-file write port
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prio_q <= PRIO_WB0;
            wr_q   <= '0;
        end else begin
            prio_q <= prio_d;
            wr_q   <= wr_d;
        end
    end

    assign Wb0_Ready = wb0_grant;
    assign Wb1_Ready = wb1_grant;
    assign RF_Load   = wr_q.valid;
    assign RF_DR     = wr_q.dr;
    assign RF_Data   = wr_q.data;

    reg_scoreboard u_scoreboard (
        .clk_i         (Clk),
        .rst_i         (Reset),
        .issue_valid_i (Issue_Valid),
        .issue_dr_i    (Issue_DR),
        .issue_ready_o (Issue_Ready),
        .clr_valid_i   (wr_q.valid),
        .clr_dr_i      (wr_q.dr),
        .sr1_i         (SR1),
        .sr2_i         (SR2),
        .sr1_busy_o    (SR1_Busy),
        .sr2_busy_o    (SR2_Busy),
        .pending_o     (Pending)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Wb0_Valid, Wb1_Valid, Issue_Valid;
    logic [2:0]  Wb0_DR, Wb1_DR, Issue_DR, SR1, SR2;
    logic [15:0] Wb0_Data, Wb1_Data;
    logic        Wb0_Ready, Wb1_Ready, Issue_Ready, SR1_Busy, SR2_Busy, RF_Load;
    logic [2:0]  RF_DR;
    logic [15:0] RF_Data;
    logic [7:0]  Pending;

    regfile_wb_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .Wb0_Valid(Wb0_Valid), .Wb0_DR(Wb0_DR), .Wb0_Data(Wb0_Data), .Wb0_Ready(Wb0_Ready),
        .Wb1_Valid(Wb1_Valid), .Wb1_DR(Wb1_DR), .Wb1_Data(Wb1_Data), .Wb1_Ready(Wb1_Ready),
        .Issue_Valid(Issue_Valid), .Issue_DR(Issue_DR), .Issue_Ready(Issue_Ready),
        .SR1(SR1), .SR2(SR2), .SR1_Busy(SR1_Busy), .SR2_Busy(SR2_Busy),
        .RF_Load(RF_Load), .RF_DR(RF_DR), .RF_Data(RF_Data), .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Reference state: scoreboard bits, preferred requester, last register-file write
    logic [7:0]  m_pend;
    logic        m_pref;
    logic        m_load;
    logic [2:0]  m_dr;
    logic [15:0] m_data;
    int          last_winner = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00;
        m_pref = 1'b0;
        m_load = 1'b0;
        m_dr   = 3'd0;
        m_data = 16'h0000;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic step();
        int         winner;
        logic [7:0] np;
        #1;
        if (Wb0_Valid && Wb1_Valid) winner = m_pref ? 1 : 0;
        else if (Wb0_Valid)         winner = 0;
        else if (Wb1_Valid)         winner = 1;
        else                        winner = -1;
        last_winner = winner;
        chk("wb0_ready", 32'(Wb0_Ready), 32'(winner == 0));
        chk("wb1_ready", 32'(Wb1_Ready), 32'(winner == 1));
        chk("issue_ready", 32'(Issue_Ready), 32'(!m_pend[Issue_DR]));
        chk("sr1_busy", 32'(SR1_Busy), 32'(m_pend[SR1]));
        chk("sr2_busy", 32'(SR2_Busy), 32'(m_pend[SR2]));
        chk("pending", 32'(Pending), 32'(m_pend));
        chk("rf_load", 32'(RF_Load), 32'(m_load));
        chk("rf_dr", 32'(RF_DR), 32'(m_dr));
        chk("rf_data", 32'(RF_Data), 32'(m_data));
        np = m_pend;
        if (m_load) np[m_dr] = 1'b0;
        if (Issue_Valid && !m_pend[Issue_DR]) np[Issue_DR] = 1'b1;
        @(posedge Clk);
        m_pend = np;
        m_load = (winner >= 0);
        if (winner == 0) begin
            m_dr = Wb0_DR; m_data = Wb0_Data; m_pref = 1'b1;
        end else if (winner == 1) begin
            m_dr = Wb1_DR; m_data = Wb1_Data; m_pref = 1'b0;
        end
        @(negedge Clk);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        #1;
        chk("rst_rf_load", 32'(RF_Load), 32'd0);
        chk("rst_rf_dr", 32'(RF_DR), 32'd0);
        chk("rst_rf_data", 32'(RF_Data), 32'd0);
        chk("rst_pending", 32'(Pending), 32'd0);
        chk("rst_wb0_ready", 32'(Wb0_Ready), 32'd0);
        chk("rst_wb1_ready", 32'(Wb1_Ready), 32'd0);
        chk("rst_issue_ready", 32'(Issue_Ready), 32'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Granted or idle requesters take fresh random values; a waiting one holds still
    task automatic refresh_reqs();
        if (last_winner == 0 || !Wb0_Valid) begin
            Wb0_Valid = 1'($urandom_range(0, 1));
            Wb0_DR    = 3'($urandom_range(0, 7));
            Wb0_Data  = 16'($urandom);
        end
        if (last_winner == 1 || !Wb1_Valid) begin
            Wb1_Valid = 1'($urandom_range(0, 1));
            Wb1_DR    = 3'($urandom_range(0, 7));
            Wb1_Data  = 16'($urandom);
        end
        Issue_Valid = ($urandom_range(0, 3) == 0);
        Issue_DR    = 3'($urandom_range(0, 7));
        SR1         = 3'($urandom_range(0, 7));
        SR2         = 3'($urandom_range(0, 7));
    endtask

    initial begin
        Wb0_Valid = 0; Wb0_DR = 0; Wb0_Data = 0;
        Wb1_Valid = 0; Wb1_DR = 0; Wb1_Data = 0;
        Issue_Valid = 0; Issue_DR = 0; SR1 = 0; SR2 = 0;
        model_reset();
        @(negedge Clk);
        apply_reset();
        step();

        // Single ALU writeback lands in the register file one cycle later
        Wb0_Valid = 1; Wb0_DR = 3'd3; Wb0_Data = 16'h1234;
        step();
        Wb0_Valid = 0;
        chk("r22_load", 32'(RF_Load), 32'd1);
        chk("r22_dr", 32'(RF_DR), 32'd3);
        chk("r22_data", 32'(RF_Data), 32'h1234);
        step();

        // Issue to R5 marks it pending until a writeback to R5 commits
        Issue_Valid = 1; Issue_DR = 3'd5;
        step();
        Issue_Valid = 0; SR1 = 3'd5;
        #1;
        chk("r24_pending", 32'(Pending), 32'h20);
        chk("r24_issue_ready", 32'(Issue_Ready), 32'd0);
        chk("r24_sr1_busy", 32'(SR1_Busy), 32'd1);
        step();
        Wb1_Valid = 1; Wb1_DR = 3'd5; Wb1_Data = 16'hBEEF;
        step();
        Wb1_Valid = 0;
        step();
        chk("r24_cleared", 32'(Pending), 32'h00);
        step();

        // Issue to R5 on the cycle R5 is written: the new claim survives
        Wb0_Valid = 1; Wb0_DR = 3'd5; Wb0_Data = 16'h5A5A;
        step();
        Wb0_Valid = 0; Issue_Valid = 1; Issue_DR = 3'd5;
        step();
        Issue_Valid = 0;
        chk("r25_set_wins", 32'(Pending), 32'h20);
        step();

        // Reset right after a grant drops the write and all state
        Wb0_Valid = 1; Wb0_DR = 3'd2; Wb0_Data = 16'h0F0F;
        step();
        apply_reset();
        Wb0_Valid = 0;
        step();
        step();
        step();

        // Both requesters stay valid: strict alternation starting from Wb0
        Wb0_Valid = 1; Wb0_DR = 3'd1; Wb0_Data = 16'hAAAA;
        Wb1_Valid = 1; Wb1_DR = 3'd2; Wb1_Data = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r23_grant_wb1", 32'(Wb1_Ready), 32'(i % 2));
            step();
            if (last_winner == 0) Wb0_Data = Wb0_Data + 16'h0101;
            else                  Wb1_Data = Wb1_Data + 16'h0101;
        end
        Wb0_Valid = 0; Wb1_Valid = 0;
        chk("r23_fourth_load", 32'(RF_Load), 32'd1);
        step();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            refresh_reqs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
